// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator memory: bus ops, processor phases, FSM states.
package acc_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpFetch = 2'b01;
  localparam logic [1:0] OpSend  = 2'b10;

  localparam logic [1:0] PhaseA    = 2'd0;
  localparam logic [1:0] PhaseB    = 2'd1;
  localparam logic [1:0] PhaseSend = 2'd2;

  typedef enum logic [2:0] {
    StLoad,
    StArb,
    StWaitOp,
    StResp,
    StDone
  } mem_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible index strictly after the pointer, as one-hot and index.
module rr_arbiter #(
  parameter int unsigned N_PROC = 4,
  parameter int unsigned IdxW   = (N_PROC > 1) ? $clog2(N_PROC) : 1
) (
  input  logic [N_PROC-1:0] eligible_i,
  input  logic [IdxW-1:0]   pointer_i,
  output logic [N_PROC-1:0] grant_o,
  output logic [IdxW-1:0]   grant_idx_o
);

  logic            found;
  logic [IdxW-1:0] sel;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sel         = '0;
    for (int unsigned i = 1; i <= N_PROC; i++) begin
      sel = IdxW'((32'(pointer_i) + i) % N_PROC);
      if (!found && eligible_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        grant_idx_o  = sel;
      end
    end
  end

endmodule

// File: rtl/accumulator_memory.sv
// Operand stack and bus master for the accumulator array.
// Define ACC_MEM_STATS_EN to build the saturating SEND counter behind op_count.
module accumulator_memory
  import acc_pkg::*;
#(
  parameter int unsigned N_PROC = 4,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              start,
  input  logic [N_PROC-1:0] req,
  output logic [N_PROC-1:0] grant,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] write,
  output logic [DATA_W-1:0] read,
  output logic              signal,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic [15:0]       op_count
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IdxW  = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam logic [CntW:0] FreeMin = 2;

  mem_state_e        state_q, state_d;
  logic [CntW-1:0]   count_q, count_d, reserved_q, reserved_d;
  logic [1:0]        phase_q [N_PROC];
  logic [1:0]        phase_d [N_PROC];
  logic [N_PROC-1:0] grant_q, grant_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [DATA_W-1:0] read_q, read_d, sum_q, sum_d;
  logic              signal_q, signal_d, done_q, done_d;

  logic [DATA_W-1:0] stack [DEPTH];
  logic              push_en;
  logic [DATA_W-1:0] push_data;
  logic              send_done;

  logic [N_PROC-1:0] eligible, arb_grant;
  logic [IdxW-1:0]   arb_idx;
  logic              all_idle;
  logic [CntW:0]     free_cnt;

  assign load_ready = (state_q == StLoad) && (count_q < CntW'(DEPTH));
  // Operands neither popped nor promised to a processor already holding an A.
  assign free_cnt   = {1'b0, count_q} - {1'b0, reserved_q};

  always_comb begin
    eligible = '0;
    all_idle = 1'b1;
    for (int unsigned i = 0; i < N_PROC; i++) begin
      eligible[i] = req[i] && ((phase_q[i] != PhaseA) || (free_cnt >= FreeMin));
      if (phase_q[i] != PhaseA) all_idle = 1'b0;
    end
  end

  rr_arbiter #(
    .N_PROC(N_PROC),
    .IdxW  (IdxW)
  ) u_arb (
    .eligible_i (eligible),
    .pointer_i  (last_q),
    .grant_o    (arb_grant),
    .grant_idx_o(arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reserved_d = reserved_q;
    phase_d    = phase_q;
    grant_d    = grant_q;
    last_d     = last_q;
    read_d     = read_q;
    sum_d      = sum_q;
    signal_d   = 1'b0;
    done_d     = done_q;
    push_en    = 1'b0;
    push_data  = '0;
    send_done  = 1'b0;

    case (state_q)
      StLoad: begin
        if (load_valid && load_ready) begin
          push_en   = 1'b1;
          push_data = load_data;
          count_d   = count_q + CntW'(1);
        end
        if (start) state_d = (count_d < CntW'(2)) ? StDone : StArb;
      end
      StArb: begin
        if (count_q == CntW'(1) && reserved_q == '0 && all_idle) begin
          state_d = StDone;
        end else if (|arb_grant) begin
          grant_d = arb_grant;
          last_d  = arb_idx;
          if (phase_q[arb_idx] == PhaseA) reserved_d = reserved_q + CntW'(2);
          state_d = StWaitOp;
        end
      end
      StWaitOp: begin
        // Ops that do not match the granted processor's phase are dropped.
        case (op)
          OpFetch: begin
            if (phase_q[last_q] != PhaseSend) begin
              read_d           = stack[AddrW'(count_q - CntW'(1))];
              count_d          = count_q - CntW'(1);
              reserved_d       = reserved_q - CntW'(1);
              phase_d[last_q]  = phase_q[last_q] + 2'd1;
              signal_d         = 1'b1;
              state_d          = StResp;
            end
          end
          OpSend: begin
            if (phase_q[last_q] == PhaseSend) begin
              push_en          = 1'b1;
              push_data        = write;
              count_d          = count_q + CntW'(1);
              phase_d[last_q]  = PhaseA;
              signal_d         = 1'b1;
              send_done        = 1'b1;
              state_d          = StResp;
            end
          end
          default: ;
        endcase
      end
      StResp: begin
        grant_d = '0;
        state_d = StArb;
      end
      StDone: begin
        grant_d = '0;
        done_d  = 1'b1;
        sum_d   = (count_q == '0) ? '0 : stack[0];
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StLoad;
      count_q    <= '0;
      reserved_q <= '0;
      phase_q    <= '{default: '0};
      grant_q    <= '0;
      last_q     <= IdxW'(N_PROC - 1);
      read_q     <= '0;
      sum_q      <= '0;
      signal_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reserved_q <= reserved_d;
      phase_q    <= phase_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      read_q     <= read_d;
      sum_q      <= sum_d;
      signal_q   <= signal_d;
      done_q     <= done_d;
    end
  end

  // Contents need no reset: count_q alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_en) stack[AddrW'(count_q)] <= push_data;
  end

  assign grant  = grant_q;
  assign read   = read_q;
  assign signal = signal_q;
  assign done   = done_q;
  assign sum    = sum_q;

`ifdef ACC_MEM_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count_q <= '0;
    end else if (send_done && op_count_q != 16'hFFFF) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`else
  logic unused_send_done;
  assign unused_send_done = send_done;
  assign op_count         = '0;
`endif

endmodule

// File: tb/tb_accumulator_memory.sv
// Self-checking bench: behavioural processors on the bus plus a stack model of the operand store.
module tb_accumulator_memory;

  localparam logic [1:0] BusNop   = 2'b00;
  localparam logic [1:0] BusFetch = 2'b01;
  localparam logic [1:0] BusSend  = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        start;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [1:0]  op;
  logic [31:0] write;
  logic [31:0] read;
  logic        signal;
  logic        done;
  logic [31:0] sum;
  logic [15:0] op_count;

  accumulator_memory dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .start     (start),
    .req       (req),
    .grant     (grant),
    .op        (op),
    .write     (write),
    .read      (read),
    .signal    (signal),
    .done      (done),
    .sum       (sum),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [31:0] model_q[$];
  logic [31:0] fetch_log[$];
  int          grant_log[$];
  int          sends;
  bit          done_seen, grant_seen;
  int          max_busy;

  // Processor state
  logic [3:0]  active;
  int          pph[4];
  logic [31:0] pa[4], pb[4];
  bit          pending;
  logic [1:0]  issued_op;
  logic [31:0] issued_write;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] exp_opc(input int n);
`ifdef ACC_MEM_STATS_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  // Processors: fetch A, fetch B, send A+B; request whenever active.
  initial begin
    op = BusNop; write = '0; req = '0; pending = 0;
    issued_op = BusNop; issued_write = '0;
    for (int i = 0; i < 4; i++) begin pph[i] = 0; pa[i] = '0; pb[i] = '0; end
    forever begin
      int gi;
      @(posedge clk); #1;
      if (reset) begin
        for (int i = 0; i < 4; i++) pph[i] = 0;
        pending = 0; op = BusNop; req = '0;
      end else begin
        gi = -1;
        for (int i = 0; i < 4; i++) if (grant[i]) gi = i;
        if (pending && signal && gi >= 0) begin
          if (issued_op == BusFetch) begin
            if (pph[gi] == 0) pa[gi] = read; else pb[gi] = read;
            pph[gi] = pph[gi] + 1;
          end else begin
            pph[gi] = 0;
          end
          pending = 0;
          op = BusNop;
        end else if (!pending && gi >= 0 && !signal) begin
          if (pph[gi] == 2) begin
            op = BusSend; write = pa[gi] + pb[gi];
            issued_op = BusSend; issued_write = pa[gi] + pb[gi];
          end else begin
            op = BusFetch; issued_op = BusFetch;
          end
          pending = 1;
        end
        req = active;
      end
    end
  end

  // Per-cycle comparison against the stack model.
  initial begin
    bit         prev_sig;
    logic [3:0] prev_grant;
    prev_sig = 0; prev_grant = '0;
    forever begin
      int busy;
      @(negedge clk);
      if (reset) begin
        prev_sig = 0; prev_grant = '0;
      end else begin
        chk("grant_onehot", 32'($onehot0(grant)), 1);
        if (prev_sig) chk("grant_release", 32'(grant), 0);
        if (signal) begin
          chk("signal_width", 32'(prev_sig), 0);
          chk("signal_granted", 32'(grant != '0), 1);
          if (issued_op == BusFetch) begin
            if (model_q.size() == 0) chk("fetch_nonempty", 0, 1);
            else chk("fetch_read", read, model_q.pop_back());
            fetch_log.push_back(read);
          end else begin
            model_q.push_back(issued_write);
            sends++;
          end
        end
        if (grant != '0 && prev_grant == '0) begin
          for (int i = 0; i < 4; i++) if (grant[i]) grant_log.push_back(i);
          grant_seen = 1;
        end
        busy = 0;
        for (int i = 0; i < 4; i++) if (pph[i] != 0) busy++;
        if (busy > max_busy) max_busy = busy;
        if (done && !done_seen) begin
          done_seen = 1;
          chk("done_model_size", 32'(model_q.size()), 1);
          if (model_q.size() > 0) chk("done_sum_model", sum, model_q[0]);
          chk("done_op_count", 32'(op_count), exp_opc(sends));
          chk("done_grant_low", 32'(grant), 0);
        end
        prev_sig = signal;
        prev_grant = grant;
      end
    end
  end

  task automatic clear_model();
    model_q.delete(); fetch_log.delete(); grant_log.delete();
    sends = 0; done_seen = 0; grant_seen = 0; max_busy = 0;
  endtask

  task automatic do_reset();
    reset = 1; active = '0; load_valid = 0; start = 0;
    @(posedge clk); #1;
    clear_model();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_signal"}, 32'(signal), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_op_count"}, 32'(op_count), 0);
    chk({tag, "_load_ready"}, 32'(load_ready), 1);
  endtask

  task automatic push(input logic [31:0] v);
    chk("load_ready", 32'(load_ready), 1);
    load_valid = 1; load_data = v;
    model_q.push_back(v);
    @(posedge clk); #1;
    load_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    chk("done_reached", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    reset = 1; active = '0; load_valid = 0; load_data = '0; start = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 0;

    // 1: one processor, operands 3,5
    active = 4'b0001;
    push(3); push(5);
    pulse_start();
    wait_done(300);
    chk("t1_nfetch", 32'(fetch_log.size()), 2);
    if (fetch_log.size() >= 2) begin
      chk("t1_fetch0", fetch_log[0], 5);
      chk("t1_fetch1", fetch_log[1], 3);
    end
    chk("t1_sum", sum, 8);
    chk("t1_op_count", 32'(op_count), exp_opc(1));

    // 2 + 4: four processors, 1..8, req held high throughout
    do_reset();
    active = 4'b1111;
    for (int v = 1; v <= 8; v++) push(32'(v));
    pulse_start();
    wait_done(2000);
    chk("t2_sum", sum, 36);
    chk("t2_op_count", 32'(op_count), exp_opc(7));
    chk("t4_ngrants", 32'(grant_log.size() >= 5), 1);
    if (grant_log.size() >= 5) begin
      chk("t4_rr0", 32'(grant_log[0]), 0);
      chk("t4_rr1", 32'(grant_log[1]), 1);
      chk("t4_rr2", 32'(grant_log[2]), 2);
      chk("t4_rr3", 32'(grant_log[3]), 3);
      chk("t4_rr4", 32'(grant_log[4]), 0);
    end

    // 3: three operands, two processors both starting in phase 0
    do_reset();
    active = 4'b0011;
    push(10); push(20); push(30);
    pulse_start();
    wait_done(1000);
    chk("t3_sum", sum, 60);
    chk("t3_max_busy", 32'(max_busy), 1);
    chk("t3_op_count", 32'(op_count), exp_opc(2));

    // 5: reset during RESP
    do_reset();
    active = 4'b1111;
    for (int v = 1; v <= 8; v++) push(32'(v));
    pulse_start();
    k = 0;
    while (!signal && k < 200) begin @(negedge clk); k++; end
    chk("t5_signal_seen", 32'(signal), 1);
    reset = 1;
    #1;
    check_reset_vals("t5_async");
    @(posedge clk); #1;
    check_reset_vals("t5_next");
    do_reset();
    push(7);
    pulse_start();
    wait_done(100);
    chk("t5_sum_after_discard", sum, 7);

    // 6: lone operand goes straight to done
    do_reset();
    active = 4'b1111;
    push(42);
    pulse_start();
    wait_done(100);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_sum", sum, 42);
    chk("t6_no_grant", 32'(grant_seen), 0);
    chk("t6_op_count", 32'(op_count), 0);
    chk("t6_done_sticky", 32'(done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
